imem_fetch_bridge: RTL and testbench
====================================

// Module: imem_fetch_bridge
// PURPOSE
//  Sits directly upstream of fetch: converts its one-word if2mem request (addr, req; req=0 means kill) into a
//  req/gnt/rvalid instruction bus transaction and returns mem2if (r_data, ack). Holds a 1-entry last-word buffer
//  so repeated fetches of a stalled PC ack in 0 cycles. Discards stale responses after kill/redirect, and
//  reports bus errors and timeouts as access faults.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles waiting for gnt/rvalid before declaring a fault (>=2)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        reset, synchronous, active-low
//  if2mem_i       in   struct   type_if2mem_s from fetch: addr[`XLEN-1:0], req
//  mem2if_o       out  struct   type_mem2if_s to fetch: r_data[`XLEN-1:0], ack
//  acc_fault_o    out  1        qualifies mem2if_o.ack: word is a faulted fetch (EXC_CODE_INSTR_ACCESS_FAULT)
//  fence_i_i      in   1        invalidate last-word buffer
//  ibus_req_o     out  1        bus request; held until gnt
//  ibus_addr_o    out  `XLEN    bus word address, stable while ibus_req_o && !ibus_gnt_i
//  ibus_gnt_i     in   1        request accepted
//  ibus_rvalid_i  in   1        response valid; exactly one per grant, >=1 cycle after gnt
//  ibus_rdata_i   in   `XLEN    response data
//  ibus_err_i     in   1        response error, qualified by rvalid
// BEHAVIOUR
//  Reset: state IDLE, buf_valid=0, stale=0, timer=0; ibus_req_o=0, mem2if_o.ack=0, r_data=0, acc_fault_o=0.
//  Hit = if2mem.req & buf_valid & (if2mem.addr==buf_addr) & ~fence_i_i; fence_i wins over a same-cycle hit.
//  Max one outstanding bus transaction. States:
//   IDLE:     hit -> ack=1, r_data=buf_data same cycle, stay. req & miss -> ibus_req_o=1, ibus_addr_o=if2mem.addr
//             (combinational), latch req_addr, stale=0; gnt ? WAIT_RSP : WAIT_GNT. req=0 -> idle, no bus activity.
//   WAIT_GNT: drive latched req_addr; gnt -> WAIT_RSP. Request not withdrawn on kill; stale is set instead.
//   WAIT_RSP: ibus_req_o=0. On rvalid -> IDLE; if ~stale & if2mem.req & addr==req_addr: ack=1 same cycle;
//             ~err: r_data=ibus_rdata_i, buffer <= {req_addr, rdata, valid};
//             err: r_data=`INSTR_NOP, acc_fault_o=1, buf_valid<=0. Otherwise response dropped, no ack.
//   DRAIN:    entered on timeout; no new requests; ack=0; on rvalid (dropped) -> IDLE.
//  stale: set (sticky) in WAIT_GNT/WAIT_RSP on any cycle with if2mem.req=0 or if2mem.addr!=req_addr;
//   also evaluated combinationally in the rvalid cycle. After a stale drop, a miss at new addr issues next cycle.
//  Timeout: timer counts cycles in WAIT_GNT/WAIT_RSP, cleared on each state entry; timer==TIMEOUT_CYCLES-1
//   without gnt/rvalid -> if ~stale: ack=1, r_data=`INSTR_NOP, acc_fault_o=1. WAIT_GNT: -> IDLE and drop
//   ibus_req_o (bus must tolerate abort before gnt); WAIT_RSP: -> DRAIN.
//  ack and acc_fault_o are single-cycle. r_data=0 whenever ack=0.
//  Latency: hit 0 cycles; miss with immediate gnt and rvalid 1 cycle later -> ack 1 cycle after request.
//  fence_i_i in any state: buf_valid<=0 next cycle; an in-flight fill completing same cycle as fence_i_i
//   does not set buf_valid.
//  Mid-operation reset: all state cleared; bus must also be reset (an outstanding rvalid is not tracked).
// STRUCTURE
//  Shared package (mem_defs.svh): type_ibus_state_e {IBUS_IDLE, IBUS_WAIT_GNT, IBUS_WAIT_RSP, IBUS_DRAIN};
//   type_ibus_req_s {req, addr}; type_ibus_rsp_s {gnt, rvalid, rdata, err}; `INSTR_NOP reused from there.
//  One sub-module: imem_last_word_buf (addr/data/valid regs, hit compare, fill, invalidate).
//  FSM, stale flag and timeout counter stay in the top module.
// TESTING
//  1 Miss then re-fetch: req addr 0x100, gnt same cycle, rvalid+rdata 0x00000013 next -> ack, r_data 0x13;
//    next cycle same addr -> ack in 0 cycles, no ibus_req_o.
//  2 Kill: gnt for 0x200, req=0 next cycle, rvalid 2 cycles later -> no ack, no buffer fill; new req 0x300
//    -> ibus_req_o 0x300 the cycle after the drop.
//  3 Bus error: addr 0x400, rvalid with err=1 -> ack=1, r_data=0x00000013, acc_fault_o=1, buf_valid=0.
//  4 Timeout: TIMEOUT_CYCLES=4, gnt never asserted -> ack+fault on 4th cycle, ibus_req_o low next cycle, IDLE.
//  5 fence_i: buffer holds 0x100; fence_i_i with req 0x100 same cycle -> no hit, bus request for 0x100 issued.
//  6 Back-pressure: gnt low 3 cycles -> ibus_addr_o and ibus_req_o stable; redirect in cycle 2 -> response dropped.

Source files
------------

// File: rtl/imem_fetch_bridge_pkg.sv
// Shared types and constants for the instruction-memory fetch bridge.
package imem_fetch_bridge_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), returned with faulted fetches.
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IBUS_IDLE,
    IBUS_WAIT_GNT,
    IBUS_WAIT_RSP,
    IBUS_DRAIN
  } type_ibus_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            req;
  } type_if2mem_s;

  typedef struct packed {
    logic [XLEN-1:0] r_data;
    logic            ack;
  } type_mem2if_s;

  typedef struct packed {
    logic            req;
    logic [XLEN-1:0] addr;
  } type_ibus_req_s;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;
  } type_ibus_rsp_s;

endpackage

// File: rtl/imem_fetch_bridge_if.sv
// Instruction bus: request side (req/addr) and response side (gnt/rvalid/rdata/err).
interface imem_fetch_bridge_if;
  import imem_fetch_bridge_pkg::*;

  type_ibus_req_s req;
  type_ibus_rsp_s rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/imem_last_word_buf.sv
// One-entry buffer holding the most recently fetched word for zero-latency re-fetch.
module imem_last_word_buf
  import imem_fetch_bridge_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_req,
  input  logic [XLEN-1:0] lookup_addr,
  input  logic            fence_i,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_addr,
  input  logic [XLEN-1:0] fill_data,
  input  logic            inv_en,
  output logic            hit,
  output logic [XLEN-1:0] buf_data
);

  logic            valid_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;

  // fence_i suppresses a same-cycle hit so the word is refetched from memory.
  assign hit      = lookup_req & valid_q & (lookup_addr == addr_q) & ~fence_i;
  assign buf_data = data_q;

  // Fill/invalidate; fence_i beats a fill completing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fence_i || inv_en) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

endmodule

// File: rtl/imem_fetch_bridge.sv
// Fetch-to-instruction-bus bridge with last-word buffer, kill handling and timeout faults.
//
// state         | meaning
// IBUS_IDLE     | no transaction; serve hits, issue misses
// IBUS_WAIT_GNT | request driven, waiting for gnt
// IBUS_WAIT_RSP | granted, waiting for rvalid
// IBUS_DRAIN    | timed out after gnt; swallow the late rvalid
module imem_fetch_bridge
  import imem_fetch_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  type_if2mem_s               if2mem_i,
  output type_mem2if_s               mem2if_o,
  output logic                       acc_fault_o,
  input  logic                       fence_i_i,
  imem_fetch_bridge_if.master        ibus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  type_ibus_state_e state_q, state_d;
  logic             stale_q, stale_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;

  logic             bus_req;
  logic [XLEN-1:0]  bus_addr;
  logic             ack;
  logic [XLEN-1:0]  r_data;
  logic             fault;
  logic             fill_en;
  logic             inv_en;
  logic             hit;
  logic [XLEN-1:0]  buf_data;
  logic             stale_now;
  logic             timed_out;

  imem_last_word_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_req  (if2mem_i.req),
    .lookup_addr (if2mem_i.addr),
    .fence_i     (fence_i_i),
    .fill_en     (fill_en),
    .fill_addr   (req_addr_q),
    .fill_data   (ibus.rsp.rdata),
    .inv_en      (inv_en),
    .hit         (hit),
    .buf_data    (buf_data)
  );

  // State, stale flag, timeout timer and latched request address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IBUS_IDLE;
      stale_q    <= 1'b0;
      timer_q    <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      stale_q    <= stale_d;
      timer_q    <= timer_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state and all outputs; everything is held at zero while in reset.
  always_comb begin
    state_d    = state_q;
    stale_d    = stale_q;
    timer_d    = timer_q;
    req_addr_d = req_addr_q;
    bus_req    = 1'b0;
    bus_addr   = req_addr_q;
    ack        = 1'b0;
    r_data     = '0;
    fault      = 1'b0;
    fill_en    = 1'b0;
    inv_en     = 1'b0;
    // Fetch has moved on (kill or redirect) if it no longer asks for req_addr.
    stale_now  = stale_q | ~if2mem_i.req | (if2mem_i.addr != req_addr_q);
    timed_out  = (timer_q == TIMER_LAST);
    if (rst_n) begin
      case (state_q)
        IBUS_IDLE: begin
          if (hit) begin
            ack    = 1'b1;
            r_data = buf_data;
          end else if (if2mem_i.req) begin
            bus_req    = 1'b1;
            bus_addr   = if2mem_i.addr;
            req_addr_d = if2mem_i.addr;
            stale_d    = 1'b0;
            timer_d    = '0;
            state_d    = ibus.rsp.gnt ? IBUS_WAIT_RSP : IBUS_WAIT_GNT;
          end
        end
        IBUS_WAIT_GNT: begin
          bus_req = 1'b1;
          stale_d = stale_now;
          if (ibus.rsp.gnt) begin
            state_d = IBUS_WAIT_RSP;
            timer_d = '0;
          end else if (timed_out) begin
            // Abort before gnt: the request simply drops next cycle.
            state_d = IBUS_IDLE;
            timer_d = '0;
            if (!stale_now) begin
              ack    = 1'b1;
              r_data = INSTR_NOP;
              fault  = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        IBUS_WAIT_RSP: begin
          stale_d = stale_now;
          if (ibus.rsp.rvalid) begin
            state_d = IBUS_IDLE;
            timer_d = '0;
            if (!stale_now) begin
              ack = 1'b1;
              if (ibus.rsp.err) begin
                r_data = INSTR_NOP;
                fault  = 1'b1;
                inv_en = 1'b1;
              end else begin
                r_data  = ibus.rsp.rdata;
                fill_en = 1'b1;
              end
            end
          end else if (timed_out) begin
            // The grant is still owed an rvalid; wait it out in DRAIN.
            state_d = IBUS_DRAIN;
            timer_d = '0;
            if (!stale_now) begin
              ack    = 1'b1;
              r_data = INSTR_NOP;
              fault  = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        IBUS_DRAIN: begin
          if (ibus.rsp.rvalid) begin
            state_d = IBUS_IDLE;
          end
        end
        default: state_d = IBUS_IDLE;
      endcase
    end
  end

  assign ibus.req        = '{req: bus_req, addr: bus_addr};
  assign mem2if_o.ack    = ack;
  assign mem2if_o.r_data = r_data;
  assign acc_fault_o     = fault;

endmodule

// File: tb/tb_imem_fetch_bridge.sv
// Directed scenarios followed by randomized fetch/bus traffic against a transaction-level model.
module tb_imem_fetch_bridge;
  import imem_fetch_bridge_pkg::*;

  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  type_if2mem_s if2mem;
  type_mem2if_s mem2if;
  logic         acc_fault;
  logic         fence;

  imem_fetch_bridge_if ibus ();

  imem_fetch_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if2mem_i    (if2mem),
    .mem2if_o    (mem2if),
    .acc_fault_o (acc_fault),
    .fence_i_i   (fence),
    .ibus        (ibus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding fetch described by flags, plus the buffered word.
  bit          m_busy, m_granted, m_drain, m_doomed;
  int          m_age;
  logic [31:0] m_taddr;
  bit          m_bv;
  logic [31:0] m_ba, m_bd;

  // Last sampled DUT outputs and last expected ack.
  logic        o_ack, o_fault, o_req;
  logic [31:0] o_data, o_addr;
  bit          x_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9e37_79b9 + 32'h0000_1013;
  endfunction

  function automatic bit model_wants_bus(input bit rq, input logic [31:0] ad, input bit fe);
    if (!rst_n) return 1'b0;
    if (!m_busy) return rq && !(m_bv && ad == m_ba && !fe);
    return !m_granted && !m_drain;
  endfunction

  task automatic drive_cycle(input bit rq, input logic [31:0] ad, input bit fe,
                             input bit gn, input bit rv, input logic [31:0] rd, input bit er);
    bit          hit, gone, e_req, e_ack, e_fault;
    logic [31:0] e_addr, e_data;
    if2mem.req = rq;
    if2mem.addr = ad;
    fence = fe;
    ibus.rsp.gnt = gn;
    ibus.rsp.rvalid = rv;
    ibus.rsp.rdata = rd;
    ibus.rsp.err = er;
    hit = rq && m_bv && (ad == m_ba) && !fe;
    gone = m_doomed || !rq || (ad != m_taddr);
    e_req = 0; e_addr = 0; e_ack = 0; e_data = 0; e_fault = 0;
    if (rst_n) begin
      if (!m_busy) begin
        if (hit) begin e_ack = 1; e_data = m_bd; end
        else if (rq) begin e_req = 1; e_addr = ad; end
      end else if (!m_drain) begin
        if (!m_granted) begin
          e_req = 1; e_addr = m_taddr;
          if (!gn && m_age == T - 1 && !gone) begin e_ack = 1; e_data = INSTR_NOP; e_fault = 1; end
        end else if (rv) begin
          if (!gone) begin e_ack = 1; e_data = er ? INSTR_NOP : rd; e_fault = er; end
        end else if (m_age == T - 1 && !gone) begin
          e_ack = 1; e_data = INSTR_NOP; e_fault = 1;
        end
      end
    end
    #3;
    o_ack = mem2if.ack; o_data = mem2if.r_data; o_fault = acc_fault;
    o_req = ibus.req.req; o_addr = ibus.req.addr;
    x_ack = e_ack;
    check_val("ack", {31'd0, o_ack}, {31'd0, e_ack});
    check_val("r_data", o_data, e_data);
    check_val("acc_fault", {31'd0, o_fault}, {31'd0, e_fault});
    check_val("ibus_req", {31'd0, o_req}, {31'd0, e_req});
    if (e_req) check_val("ibus_addr", o_addr, e_addr);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 0; m_granted = 0; m_drain = 0; m_doomed = 0; m_age = 0;
      m_taddr = 0; m_bv = 0; m_ba = 0; m_bd = 0;
    end else begin
      if (!m_busy) begin
        if (rq && !hit) begin
          m_busy = 1; m_granted = gn; m_drain = 0; m_doomed = 0; m_age = 0; m_taddr = ad;
        end
      end else if (m_drain) begin
        if (rv) begin m_busy = 0; m_drain = 0; end
      end else if (!m_granted) begin
        if (gn) begin m_granted = 1; m_age = 0; m_doomed = gone; end
        else if (m_age == T - 1) m_busy = 0;
        else begin m_age++; m_doomed = gone; end
      end else begin
        if (rv) begin
          m_busy = 0; m_granted = 0;
          if (!gone) begin
            if (er) m_bv = 0;
            else begin m_bv = 1; m_ba = m_taddr; m_bd = rd; end
          end
        end else if (m_age == T - 1) begin
          m_drain = 1; m_granted = 0;
        end else begin
          m_age++; m_doomed = gone;
        end
      end
      if (fe) m_bv = 0;
    end
  endtask

  initial begin
    int          rsp_wait;
    logic [31:0] rsp_addr, cur_addr, ga;
    bit          cur_req, fe, gn, rv, er;

    ibus.rsp = '0;
    if2mem = '0;
    fence = 1'b0;
    m_busy = 0; m_granted = 0; m_drain = 0; m_doomed = 0; m_age = 0;
    m_taddr = 0; m_bv = 0; m_ba = 0; m_bd = 0;
    #1;

    // Reset: outputs quiet even with a request presented.
    rst_n = 1'b0;
    drive_cycle(1, 32'h100, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h100, 0, 0, 0, 0, 0);
    check_val("reset_ack", {31'd0, o_ack}, 32'd0);
    check_val("reset_req", {31'd0, o_req}, 32'd0);
    rst_n = 1'b1;

    // Miss with immediate gnt, then 0-cycle re-fetch from the buffer.
    drive_cycle(1, 32'h100, 0, 1, 0, 0, 0);
    check_val("t1_issue_addr", o_addr, 32'h100);
    drive_cycle(1, 32'h100, 0, 0, 1, 32'h13, 0);
    check_val("t1_ack", {31'd0, o_ack}, 32'd1);
    check_val("t1_data", o_data, 32'h13);
    drive_cycle(1, 32'h100, 0, 0, 0, 0, 0);
    check_val("t1_hit_ack", {31'd0, o_ack}, 32'd1);
    check_val("t1_hit_noreq", {31'd0, o_req}, 32'd0);

    // Kill after gnt: response dropped, next address issued the cycle after.
    drive_cycle(1, 32'h200, 0, 1, 0, 0, 0);
    drive_cycle(0, 32'h200, 0, 0, 0, 0, 0);
    drive_cycle(0, 32'h200, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h300, 0, 0, 1, 32'hdead_beef, 0);
    check_val("t2_drop_ack", {31'd0, o_ack}, 32'd0);
    drive_cycle(1, 32'h300, 0, 0, 0, 0, 0);
    check_val("t2_reissue_req", {31'd0, o_req}, 32'd1);
    check_val("t2_reissue_addr", o_addr, 32'h300);
    drive_cycle(1, 32'h300, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h300, 0, 0, 1, mem_word(32'h300), 0);

    // Bus error: NOP with fault, buffer invalidated.
    drive_cycle(1, 32'h400, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h400, 0, 0, 1, 32'h1234, 1);
    check_val("t3_fault", {31'd0, o_fault}, 32'd1);
    check_val("t3_nop", o_data, 32'h13);
    drive_cycle(1, 32'h300, 0, 0, 0, 0, 0);
    check_val("t3_buf_invalid", {31'd0, o_req}, 32'd1);
    drive_cycle(1, 32'h300, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h300, 0, 0, 1, mem_word(32'h300), 0);

    // Timeout with no gnt: fault on 4th waiting cycle, request dropped after.
    drive_cycle(1, 32'h500, 0, 0, 0, 0, 0);
    for (int i = 0; i < T - 1; i++) drive_cycle(1, 32'h500, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h500, 0, 0, 0, 0, 0);
    check_val("t4_timeout_fault", {31'd0, o_fault}, 32'd1);
    drive_cycle(0, 32'h500, 0, 0, 0, 0, 0);
    check_val("t4_req_dropped", {31'd0, o_req}, 32'd0);

    // fence_i beats a same-cycle hit.
    drive_cycle(1, 32'h100, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h100, 0, 0, 1, 32'h13, 0);
    drive_cycle(1, 32'h100, 1, 0, 0, 0, 0);
    check_val("t5_no_hit", {31'd0, o_ack}, 32'd0);
    check_val("t5_req_addr", o_addr, 32'h100);
    drive_cycle(1, 32'h100, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h100, 0, 0, 1, 32'h13, 0);

    // Back-pressure with redirect while waiting for gnt.
    drive_cycle(1, 32'h600, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h600, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h604, 0, 0, 0, 0, 0);
    check_val("t6_addr_stable", o_addr, 32'h600);
    drive_cycle(1, 32'h604, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h604, 0, 0, 1, mem_word(32'h600), 0);
    check_val("t6_dropped", {31'd0, o_ack}, 32'd0);
    drive_cycle(1, 32'h604, 0, 0, 0, 0, 0);
    check_val("t6_new_addr", o_addr, 32'h604);
    drive_cycle(1, 32'h604, 0, 1, 0, 0, 0);
    drive_cycle(1, 32'h604, 0, 0, 1, mem_word(32'h604), 0);

    // Random traffic, with a mid-run reset of bridge and bus together.
    rsp_wait = -1;
    rsp_addr = 0;
    cur_req = 0;
    cur_addr = 32'h100;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        drive_cycle(1, 32'h104, 0, 0, 0, 0, 0);
        drive_cycle(0, 32'h104, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        rsp_wait = -1;
        cur_req = 0;
      end
      if (x_ack || !cur_req) begin
        cur_req = ($urandom_range(0, 3) != 0);
        cur_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      end else if ($urandom_range(0, 9) == 0) begin
        cur_req = ($urandom_range(0, 2) != 0);
        cur_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      end
      fe = ($urandom_range(0, 19) == 0);
      rv = (rsp_wait == 0);
      er = rv && ($urandom_range(0, 7) == 0);
      gn = 0;
      if (model_wants_bus(cur_req, cur_addr, fe) && rsp_wait < 0)
        gn = ($urandom_range(0, 2) != 0);
      ga = m_busy ? m_taddr : cur_addr;
      drive_cycle(cur_req, cur_addr, fe, gn, rv, mem_word(rsp_addr), er);
      if (rv) rsp_wait = -1;
      else if (rsp_wait > 0) rsp_wait--;
      if (gn) begin
        rsp_wait = $urandom_range(0, 5);
        rsp_addr = ga;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
